eth_phy_rx_ber_mon_mlane: RTL
=============================

Name: eth_phy_rx_ber_mon_mlane

Overview:
Multi-lane, parametrised BER monitor for the 10G/25G/40G PCS receive path. It sits between the per-lane RX gearbox/block-lock logic and the PCS status and statistics logic. Each lane gets an independent high-BER state machine with a configurable threshold, gated by header-valid, plus a saturating errored-header statistics counter. All lanes share one 125 us window timer.

Parameters:
LANES, 1, number of independent lanes (1..8)
HDR_WIDTH, 2, sync header width per lane; must be 2 (elaboration error otherwise)
COUNT_125US, 125000/6.4, window length in clk cycles (integer part)
BER_THRESH, 16, invalid headers within one window that assert high BER (2..255)
ERR_CNT_WIDTH, 16, width of per-lane errored-header statistics counter

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
serdes_rx_hdr  input  LANES*HDR_WIDTH  lane n header at [2n+1:2n]
serdes_rx_hdr_valid  input  LANES  header qualifier per lane (gearbox slip cycles low)
lane_enable  input  LANES  per-lane enable; disabled lanes are held idle
stat_clear  input  1  single-cycle pulse, zeroes all statistics counters
rx_high_ber  output  LANES  per-lane high-BER status
rx_high_ber_any  output  1  OR of rx_high_ber over enabled lanes, registered
stat_err_count  output  LANES*ERR_CNT_WIDTH  per-lane saturating errored-header count

Behaviour:
- Header classification: 2'b01 (ctrl) and 2'b10 (data) are valid; 2'b00 and 2'b11 are invalid. A header is evaluated only when its hdr_valid bit is 1 and its lane is enabled.
- Window timer: shared, width $clog2(COUNT_125US+1). Reset value is COUNT_125US. It decrements every cycle regardless of hdr_valid. "Expire" means the timer is 0 this cycle. On expire it reloads COUNT_125US on the next edge.
- Per-lane ber_count: width $clog2(BER_THRESH). Saturates at BER_THRESH-1.
  - An evaluated invalid header with ber_count < BER_THRESH-1 increments it.
  - An evaluated invalid header with ber_count == BER_THRESH-1 sets rx_high_ber the next cycle, so the BER_THRESH-th invalid header in a window asserts it with 1-cycle latency.
- Expire (per lane, same cycle):
  - ber_count goes to 0.
  - rx_high_ber is cleared iff ber_count != BER_THRESH-1 that cycle.
  - If the expire-cycle header is the BER_THRESH-th invalid one, set wins over clear, and ber_count still goes to 0.
- rx_high_ber is sticky between windows otherwise. Minimum clear latency after the errors stop is one full window.
- stat_err_count:
  - Increments by 1 per evaluated invalid header and saturates at all-ones.
  - stat_clear has priority over a same-cycle increment: the result is 0 and that error is not counted.
- lane_enable = 0: ber_count and rx_high_ber are forced to 0 next cycle, and stat_err_count holds. On re-enable the lane resumes with the current shared window; no timer restart.
- rx_high_ber_any: registered OR of the next-state rx_high_ber & lane_enable, so it is cycle-aligned with rx_high_ber.
- Reset (rst=1) sets:
  - timer = COUNT_125US
  - all ber_count = 0
  - rx_high_ber = 0, rx_high_ber_any = 0
  - stat_err_count = 0
- rst takes priority over all other inputs; a mid-window reset restarts the window.
- All outputs are registered. No combinational path from input to output.

Decomposition:
- Package eth_phy_pkg holds: SYNC_DATA=2'b10, SYNC_CTRL=2'b01, and the hdr_is_valid function.
- One sub-module, eth_phy_rx_ber_lane: per-lane ber_count, high-BER flag and stat counter. Inputs are hdr, hdr_valid, enable, window_expire, stat_clear. Instantiated LANES times by a generate loop.
- The top level owns the shared timer and the OR-reduce.

Test Plan:
All scenarios use COUNT_125US=100 and BER_THRESH=16 unless stated.
1. LANES=1, 16 invalid headers (2'b00) in consecutive cycles after reset -> rx_high_ber=1 on the cycle after the 16th. stat_err_count=16. rx_high_ber_any=1.
2. Continuing from 1, valid headers only -> rx_high_ber stays 1 until the first expire, where ber_count=15 keeps it set. It clears at the following expire (about 100 cycles later).
3. LANES=4, lane 2 gets 20 invalid headers and the others get valid headers -> only rx_high_ber[2]=1. stat_err_count lane2=20, others=0.
4. Invalid headers with hdr_valid=0 for 50 cycles -> no counting, rx_high_ber=0, stat_err_count=0.
5. ERR_CNT_WIDTH=4, 20 invalid headers -> stat_err_count=15 (saturated). stat_clear coincident with an invalid header -> 0.
6. Lane at high BER, lane_enable dropped for 1 cycle -> rx_high_ber=0 next cycle and stat_err_count unchanged. Also check rst mid-window -> timer=100 and all outputs 0.

Source files
------------

// File: rtl/eth_phy_pkg.sv
// Shared PCS receive definitions: 64b/66b sync header encodings and the
// header validity check used by the BER monitor lanes.
package eth_phy_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_rx_ber_lane.sv
// One lane of the BER monitor: windowed invalid-header counter, sticky
// high-BER flag and a saturating errored-header statistics counter.
module eth_phy_rx_ber_lane #(
    parameter int BER_THRESH    = 16,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               hdr,
    input  logic                     hdr_valid,
    input  logic                     enable,
    input  logic                     window_expire,
    input  logic                     stat_clear,
    output logic                     high_ber,
    output logic                     high_ber_nxt,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);
    import eth_phy_pkg::*;

    localparam int             CW      = $clog2(BER_THRESH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(BER_THRESH - 1);

    logic [CW-1:0]            ber_count, ber_count_nxt;
    logic [ERR_CNT_WIDTH-1:0] err_count_nxt;
    logic                     bad_hdr, at_max;

    always_comb begin
        bad_hdr       = enable & hdr_valid & ~hdr_is_valid(hdr);
        at_max        = (ber_count == CNT_MAX);
        ber_count_nxt = ber_count;
        high_ber_nxt  = high_ber;
        err_count_nxt = err_count;

        if (!enable) begin
            ber_count_nxt = '0;
            high_ber_nxt  = 1'b0;
        end else begin
            if (window_expire)
                ber_count_nxt = '0;
            else if (bad_hdr && !at_max)
                ber_count_nxt = ber_count + CW'(1);

            // Threshold hit on the expire cycle still sets the flag.
            if (bad_hdr && at_max)
                high_ber_nxt = 1'b1;
            else if (window_expire && !at_max)
                high_ber_nxt = 1'b0;
        end

        // A clear wins over a same-cycle error; that error is dropped.
        if (stat_clear)
            err_count_nxt = '0;
        else if (bad_hdr && !(&err_count))
            err_count_nxt = err_count + ERR_CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ber_count <= '0;
            high_ber  <= 1'b0;
            err_count <= '0;
        end else begin
            ber_count <= ber_count_nxt;
            high_ber  <= high_ber_nxt;
            err_count <= err_count_nxt;
        end
    end

endmodule

// File: rtl/eth_phy_rx_ber_mon_mlane.sv
// Multi-lane PCS receive BER monitor: one shared 125 us window timer feeding
// an array of independent per-lane high-BER monitors.
module eth_phy_rx_ber_mon_mlane #(
    parameter int LANES         = 1,
    parameter int HDR_WIDTH     = 2,
    parameter int COUNT_125US   = 19531,  // 125000 / 6.4, integer part
    parameter int BER_THRESH    = 16,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [LANES*HDR_WIDTH-1:0]       serdes_rx_hdr,
    input  logic [LANES-1:0]                 serdes_rx_hdr_valid,
    input  logic [LANES-1:0]                 lane_enable,
    input  logic                             stat_clear,
    output logic [LANES-1:0]                 rx_high_ber,
    output logic                             rx_high_ber_any,
    output logic [LANES*ERR_CNT_WIDTH-1:0]   stat_err_count
);
    import eth_phy_pkg::*;

    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $error("eth_phy_rx_ber_mon_mlane: HDR_WIDTH must be 2");
    end

    localparam int            TW         = $clog2(COUNT_125US + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(COUNT_125US);

    logic [TW-1:0]    timer;
    logic             window_expire;
    logic [LANES-1:0] high_ber_nxt;

    assign window_expire = (timer == '0);

    always_ff @(posedge clk) begin
        if (rst || window_expire)
            timer <= TIMER_LOAD;
        else
            timer <= timer - TW'(1);
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        eth_phy_rx_ber_lane #(
            .BER_THRESH    (BER_THRESH),
            .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .hdr           (serdes_rx_hdr[g*HDR_WIDTH +: HDR_WIDTH]),
            .hdr_valid     (serdes_rx_hdr_valid[g]),
            .enable        (lane_enable[g]),
            .window_expire (window_expire),
            .stat_clear    (stat_clear),
            .high_ber      (rx_high_ber[g]),
            .high_ber_nxt  (high_ber_nxt[g]),
            .err_count     (stat_err_count[g*ERR_CNT_WIDTH +: ERR_CNT_WIDTH])
        );
    end

    // Built from next-state flags so it lands on the same edge as rx_high_ber.
    always_ff @(posedge clk) begin
        if (rst)
            rx_high_ber_any <= 1'b0;
        else
            rx_high_ber_any <= |(high_ber_nxt & lane_enable);
    end

endmodule
